// File: rtl/game_pkg.sv
// Shared game-flow definitions.
//  game_state_t : 3-bit state encoding used by the flow FSM, the renderer and
//                 the scroll engine.
//  max_u        : helper for sizing counters from two tick parameters.
package game_pkg;

    typedef enum logic [2:0] {
        ST_START     = 3'b000,
        ST_COUNTDOWN = 3'b001,
        ST_PLAYING   = 3'b010,
        ST_PAUSED    = 3'b011,
        ST_RESPAWN   = 3'b100,
        ST_GAME_OVER = 3'b101
    } game_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_edge_pulse.sv
// edge_pulse: one-bit rising-edge detector with a cleared history on reset.
// Ports:
//  clk      in  1  system clock
//  reset    in  1  synchronous, active-high reset
//  level    in  1  synchronised input level
//  pulse_c  out 1  combinational: high for the cycle where level is 1 and was 0
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse_c
);

    logic level_prev;

    // History of the input from the previous cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level;
        end
    end

    assign pulse_c = level & ~level_prev;

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game flow FSM (start, countdown, play, pause,
// respawn, game over) with a lives counter and tick-timed phases.
// Optional feature: define GAME_FLOW_PAUSE_EN to make PAUSED reachable;
// otherwise the pause input is unused and encoding 011 is treated as illegal.
// Ports:
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-high reset
//  start       in   1       start button level
//  pause       in   1       pause button level
//  hit         in   1       collision flag (level or pulse)
//  tick        in   1       one-cycle frame strobe
//  game_state  out  3       current state, decoded from the state register
//  play_en     out  1       high iff state is PLAYING (decoded)
//  lives_left  out  LIFE_W  remaining lives (registered)
//  timer       out  TMR_W   remaining ticks in COUNTDOWN/RESPAWN, else 0 (registered)
//  new_game    out  1       one-cycle strobe after START->COUNTDOWN (registered)
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter  int unsigned LIVES           = 3,
    parameter  int unsigned COUNTDOWN_TICKS = 180,
    parameter  int unsigned RESPAWN_TICKS   = 120,
    localparam int unsigned LIFE_W          = $clog2(LIVES + 1),
    localparam int unsigned TMR_W           = $clog2(max_u(COUNTDOWN_TICKS, RESPAWN_TICKS) + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              hit,
    input  logic              tick,
    output logic [2:0]        game_state,
    output logic              play_en,
    output logic [LIFE_W-1:0] lives_left,
    output logic [TMR_W-1:0]  timer,
    output logic              new_game
);

    game_state_t       state_q, state_d;
    logic [LIFE_W-1:0] lives_q, lives_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              new_game_q, new_game_d;
    logic              start_p;
    logic              pause_p;

    edge_pulse u_start_edge (
        .clk     (clk),
        .reset   (reset),
        .level   (start),
        .pulse_c (start_p)
    );

    edge_pulse u_pause_edge (
        .clk     (clk),
        .reset   (reset),
        .level   (pause),
        .pulse_c (pause_p)
    );

`ifndef GAME_FLOW_PAUSE_EN
    // Pause edge has no consumer when the feature is compiled out.
    logic unused_pause_p;
    assign unused_pause_p = pause_p;
`endif

    // State, lives, timer and strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_START;
            lives_q    <= LIFE_W'(LIVES);
            timer_q    <= '0;
            new_game_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            timer_q    <= timer_d;
            new_game_q <= new_game_d;
        end
    end

    // Next-state, lives and timer logic.
    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        timer_d    = timer_q;
        new_game_d = 1'b0;

        case (state_q)
            ST_START: begin
                if (start_p) begin
                    state_d    = ST_COUNTDOWN;
                    lives_d    = LIFE_W'(LIVES);
                    timer_d    = TMR_W'(COUNTDOWN_TICKS);
                    new_game_d = 1'b1;
                end
            end

            // COUNTDOWN and RESPAWN share the tick timer; <=1 also covers a
            // zero timer so the count can never wrap.
            ST_COUNTDOWN, ST_RESPAWN: begin
                if (tick) begin
                    if (timer_q <= TMR_W'(1)) begin
                        state_d = ST_PLAYING;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
            end

            ST_PLAYING: begin
                // Hit takes priority over a simultaneous pause edge.
                if (hit) begin
                    if (lives_q > LIFE_W'(1)) begin
                        state_d = ST_RESPAWN;
                        lives_d = lives_q - LIFE_W'(1);
                        timer_d = TMR_W'(RESPAWN_TICKS);
                    end else begin
                        state_d = ST_GAME_OVER;
                        lives_d = '0;
                        timer_d = '0;
                    end
                end
`ifdef GAME_FLOW_PAUSE_EN
                else if (pause_p) begin
                    state_d = ST_PAUSED;
                end
`endif
            end

`ifdef GAME_FLOW_PAUSE_EN
            ST_PAUSED: begin
                if (pause_p) begin
                    state_d = ST_PLAYING;
                end
            end
`endif

            ST_GAME_OVER: begin
                if (start_p) begin
                    state_d = ST_START;
                end
            end

            // Unused encodings recover to START.
            default: begin
                state_d = ST_START;
                timer_d = '0;
            end
        endcase
    end

    assign game_state = state_q;
    assign play_en    = (state_q == ST_PLAYING);
    assign lives_left = lives_q;
    assign timer      = timer_q;
    assign new_game   = new_game_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with LIVES=3, COUNTDOWN_TICKS=3,
// RESPAWN_TICKS=60. Each step queues the expected post-edge outputs and
// checks them one cycle later.
module tb_game_flow_ctrl;
    import game_pkg::*;

    localparam int unsigned LIVES = 3;
    localparam int unsigned CT    = 3;
    localparam int unsigned RT    = 60;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, pause, hit, tick;
    logic [2:0] game_state;
    logic       play_en;
    logic [1:0] lives_left;
    logic [5:0] timer;
    logic       new_game;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       pe;
        logic [1:0] lv;
        logic [5:0] tm;
        logic       ng;
    } exp_t;

    exp_t sb[$];

    game_flow_ctrl #(
        .LIVES           (LIVES),
        .COUNTDOWN_TICKS (CT),
        .RESPAWN_TICKS   (RT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .hit        (hit),
        .tick       (tick),
        .game_state (game_state),
        .play_en    (play_en),
        .lives_left (lives_left),
        .timer      (timer),
        .new_game   (new_game)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string field, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
        end
    endtask

    // Drive inputs, queue the expectation, clock once, pop and compare.
    task automatic step(input string tag, input logic st, input logic ps, input logic ht,
                        input logic tk, input logic [2:0] es, input int el, input int et,
                        input logic eng);
        exp_t e;
        e.tag = tag;
        e.st  = es;
        e.pe  = (es == 3'b010);
        e.lv  = 2'(el);
        e.tm  = 6'(et);
        e.ng  = eng;
        sb.push_back(e);
        start = st; pause = ps; hit = ht; tick = tk;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            cmp(e.tag, "state", 8'(game_state), 8'(e.st));
            cmp(e.tag, "play_en", 8'(play_en), 8'(e.pe));
            cmp(e.tag, "lives", 8'(lives_left), 8'(e.lv));
            cmp(e.tag, "timer", 8'(timer), 8'(e.tm));
            cmp(e.tag, "new_game", 8'(new_game), 8'(e.ng));
        end
    endtask

    localparam logic [2:0] S_START = 3'b000;
    localparam logic [2:0] S_CD    = 3'b001;
    localparam logic [2:0] S_PLAY  = 3'b010;
    localparam logic [2:0] S_PAUSE = 3'b011;
    localparam logic [2:0] S_RESP  = 3'b100;
    localparam logic [2:0] S_OVER  = 3'b101;

    initial begin
        int t;
        reset = 1'b1;
        start = 1'b0; pause = 1'b0; hit = 1'b0; tick = 1'b0;

        // 1. reset for two cycles
        step("rst0", 0, 0, 0, 0, S_START, 3, 0, 0);
        step("rst1", 0, 0, 0, 0, S_START, 3, 0, 0);
        reset = 1'b0;
        step("idle", 0, 0, 0, 0, S_START, 3, 0, 0);

        // 2. start edge, countdown, held start does not retrigger
        step("start", 1, 0, 0, 0, S_CD, 3, 3, 1);
        step("cd_hold", 1, 0, 0, 0, S_CD, 3, 3, 0);
        step("cd_t1", 1, 0, 0, 1, S_CD, 3, 2, 0);
        step("cd_hit", 1, 1, 1, 1, S_CD, 3, 1, 0);
        step("cd_t3", 1, 0, 0, 1, S_PLAY, 3, 0, 0);
        step("play_hold", 1, 0, 0, 0, S_PLAY, 3, 0, 0);
        step("play_rel", 0, 0, 0, 0, S_PLAY, 3, 0, 0);

        // 3. hit -> respawn, hits ignored, timed return to PLAYING
        step("hit1", 0, 0, 1, 0, S_RESP, 2, 60, 0);
        t = 60;
        while (t > 1) begin
            t--;
            step("resp1", 0, (t == 40), (t == 59), 1, S_RESP, 2, t, 0);
        end
        step("resp1_end", 0, 0, 0, 1, S_PLAY, 2, 0, 0);
        step("hit2", 0, 0, 1, 0, S_RESP, 1, 60, 0);
        t = 60;
        while (t > 1) begin
            t--;
            step("resp2", 0, 0, 0, 1, S_RESP, 1, t, 0);
        end
        step("resp2_end", 0, 0, 0, 1, S_PLAY, 1, 0, 0);
        step("hit3", 0, 0, 1, 0, S_OVER, 0, 0, 0);
        step("over_hit", 0, 0, 1, 1, S_OVER, 0, 0, 0);
        step("over_start", 1, 0, 0, 0, S_START, 0, 0, 0);
        step("start_hold", 1, 0, 0, 0, S_START, 0, 0, 0);
        step("start_rel", 0, 0, 0, 0, S_START, 0, 0, 0);
        step("restart", 1, 0, 0, 0, S_CD, 3, 3, 1);
        step("cd2_t1", 0, 0, 0, 1, S_CD, 3, 2, 0);
        step("cd2_t2", 0, 0, 0, 1, S_CD, 3, 1, 0);
        step("cd2_t3", 0, 0, 0, 1, S_PLAY, 3, 0, 0);

        // 4. hit and pause edge together: hit wins
        step("hit_pause", 0, 1, 1, 0, S_RESP, 2, 60, 0);
        t = 60;
        repeat (10) begin
            t--;
            step("resp3", 0, 0, 0, 1, S_RESP, 2, t, 0);
        end

        // 6. reset in RESPAWN at timer 50
        reset = 1'b1;
        step("rst_mid", 1, 1, 1, 1, S_START, 3, 0, 0);
        reset = 1'b0;
        step("rst_rel", 0, 0, 0, 0, S_START, 3, 0, 0);

        // 5. pause behaviour
        step("start3", 1, 0, 0, 0, S_CD, 3, 3, 1);
        step("cd3_t1", 0, 0, 0, 1, S_CD, 3, 2, 0);
        step("cd3_t2", 0, 0, 0, 1, S_CD, 3, 1, 0);
        step("cd3_t3", 0, 0, 0, 1, S_PLAY, 3, 0, 0);
`ifdef GAME_FLOW_PAUSE_EN
        step("pause_on", 0, 1, 0, 0, S_PAUSE, 3, 0, 0);
        step("paused_tick", 0, 1, 1, 1, S_PAUSE, 3, 0, 0);
        step("paused_hit", 0, 0, 1, 0, S_PAUSE, 3, 0, 0);
        step("pause_off", 0, 1, 0, 0, S_PLAY, 3, 0, 0);
`else
        step("pause_on", 0, 1, 0, 0, S_PLAY, 3, 0, 0);
        step("pause_hold", 0, 1, 0, 1, S_PLAY, 3, 0, 0);
        step("nopause_hit", 0, 0, 1, 0, S_RESP, 2, 60, 0);
        step("nopause_resp", 0, 1, 0, 0, S_RESP, 2, 60, 0);
`endif
        step("final", 0, 0, 0, 0,
`ifdef GAME_FLOW_PAUSE_EN
             S_PLAY, 3, 0,
`else
             S_RESP, 2, 60,
`endif
             0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
